// File: rtl/flexbex_csr_cmd_initiator.sv
// Initiator-side sequencer for the flexbex CSR access port. It takes one CSR command, waits for
// the core to release the port, issues a single access cycle and returns the old CSR value.
module flexbex_csr_cmd_initiator #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [11:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [1:0]  req_op_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    input  logic        core_busy_i,
    output logic        busy_o,
    output logic        csr_access_o,
    output logic [11:0] csr_addr_o,
    output logic [31:0] csr_wdata_o,
    output logic [1:0]  csr_op_o,
    input  logic [31:0] csr_rdata_i,
    output logic [7:0]  err_cnt_o
);

    // Both channels use strict valid/ready: a transfer happens on a rising edge where valid
    // and ready are both high; once raised, valid and its payload hold until that edge.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        ISSUE = 2'd2,
        RESP  = 2'd3
    } state_e;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_e      state_q;
    logic [11:0] addr_q;
    logic [31:0] wdata_q;
    logic [1:0]  op_q;
    logic [7:0]  cnt_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic [7:0]  err_cnt_q;

    logic        ro_viol;
    logic        issue_live;
    logic [7:0]  err_cnt_d;

    // Any modifying op aimed at addr[11:10]==2'b11 is demoted to a plain read.
    assign ro_viol    = (addr_q[11:10] == 2'b11) && (op_q != 2'd0);
    assign issue_live = (state_q == ISSUE) && !rst;
    assign err_cnt_d  = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            op_q      <= '0;
            cnt_q     <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid_i) begin
                        addr_q  <= req_addr_i;
                        wdata_q <= req_wdata_i;
                        op_q    <= req_op_i;
                        cnt_q   <= '0;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    // A released port wins over an expiring timeout in the same cycle.
                    if (!core_busy_i) begin
                        state_q <= ISSUE;
                    end else if (cnt_q == TO_LAST) begin
                        rdata_q   <= '0;
                        err_q     <= 1'b1;
                        err_cnt_q <= err_cnt_d;
                        state_q   <= RESP;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                ISSUE: begin
                    rdata_q <= csr_rdata_i;
                    err_q   <= ro_viol;
                    if (ro_viol) begin
                        err_cnt_q <= err_cnt_d;
                    end
                    state_q <= RESP;
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Access and op are gated by rst directly so a reset landing in ISSUE cannot write.
    assign req_ready_o  = (state_q == IDLE) && !rst;
    assign rsp_valid_o  = (state_q == RESP);
    assign busy_o       = (state_q != IDLE);
    assign rsp_rdata_o  = rdata_q;
    assign rsp_err_o    = err_q;
    assign err_cnt_o    = err_cnt_q;
    assign csr_access_o = issue_live;
    assign csr_op_o     = (issue_live && !ro_viol) ? op_q : 2'd0;
    assign csr_addr_o   = (state_q == ISSUE) ? addr_q : 12'd0;
    assign csr_wdata_o  = (state_q == ISSUE) ? wdata_q : 32'd0;

endmodule

// File: tb/tb_flexbex_csr_cmd_initiator.sv
// Directed bench for flexbex_csr_cmd_initiator with a small behavioural CSR file on the port.
module tb_flexbex_csr_cmd_initiator;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready_o;
    logic [11:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_op;
    logic        rsp_valid_o;
    logic        rsp_ready;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic        core_busy;
    logic        busy_o;
    logic        csr_access_o;
    logic [11:0] csr_addr_o;
    logic [31:0] csr_wdata_o;
    logic [1:0]  csr_op_o;
    logic [31:0] csr_rdata;
    logic [7:0]  err_cnt_o;

    int n_vec = 0;
    int n_miscmp = 0;

    always #5 clk = ~clk;

    flexbex_csr_cmd_initiator #(.TIMEOUT_CYCLES(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready_o),
        .req_addr_i   (req_addr),
        .req_wdata_i  (req_wdata),
        .req_op_i     (req_op),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_ready_i  (rsp_ready),
        .rsp_rdata_o  (rsp_rdata_o),
        .rsp_err_o    (rsp_err_o),
        .core_busy_i  (core_busy),
        .busy_o       (busy_o),
        .csr_access_o (csr_access_o),
        .csr_addr_o   (csr_addr_o),
        .csr_wdata_o  (csr_wdata_o),
        .csr_op_o     (csr_op_o),
        .csr_rdata_i  (csr_rdata),
        .err_cnt_o    (err_cnt_o)
    );

    // Register-file stand-in: combinational read, write on the access edge.
    logic [31:0] mepc_r      = 32'h8000_0100;
    logic [31:0] mstatus_r   = 32'h0000_1800;
    logic [31:0] mhartid_r   = 32'h0000_0021;
    logic [31:0] dscratch0_r = 32'hDEAD_BEEF;

    always_comb begin
        case (csr_addr_o)
            12'h341: csr_rdata = mepc_r;
            12'h300: csr_rdata = mstatus_r;
            12'hF14: csr_rdata = mhartid_r;
            12'h7B2: csr_rdata = dscratch0_r;
            default: csr_rdata = 32'd0;
        endcase
    end

    function automatic logic [31:0] apply_op(input logic [1:0] op, input logic [31:0] old,
                                             input logic [31:0] w);
        case (op)
            2'd1:    return w;
            2'd2:    return old | w;
            2'd3:    return old & ~w;
            default: return old;
        endcase
    endfunction

    always @(posedge clk) begin
        if (csr_access_o) begin
            case (csr_addr_o)
                12'h341: mepc_r      <= apply_op(csr_op_o, mepc_r, csr_wdata_o);
                12'h300: mstatus_r   <= apply_op(csr_op_o, mstatus_r, csr_wdata_o);
                12'hF14: mhartid_r   <= apply_op(csr_op_o, mhartid_r, csr_wdata_o);
                12'h7B2: dscratch0_r <= apply_op(csr_op_o, dscratch0_r, csr_wdata_o);
                default: ;
            endcase
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miscmp++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one command at a negedge; returns at the next negedge (state WAIT).
    task automatic send(input logic [11:0] addr, input logic [1:0] op, input logic [31:0] w);
        req_addr  = addr;
        req_op    = op;
        req_wdata = w;
        req_valid = 1'b1;
        #1;
        chk("req_ready_idle", {31'd0, req_ready_o}, 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        chk("busy_after_accept", {31'd0, busy_o}, 32'd1);
    endtask

    // Follow the command to its response, then complete the handshake after `hold` stall cycles.
    task automatic run_rsp(input string tag, input int busy_cycles, input int hold,
                           input int exp_lat, input logic [31:0] exp_rdata, input logic exp_err,
                           input logic exp_acc, input logic [1:0] exp_op,
                           input logic [11:0] exp_addr, input logic [31:0] exp_wdata);
        int lat = 1;
        int k = 0;
        logic acc_seen = 1'b0;
        logic [1:0] op_seen = 2'd0;
        logic [11:0] addr_seen = 12'd0;
        logic [31:0] wdata_seen = 32'd0;
        logic leak = 1'b0;
        while (!rsp_valid_o && lat < 60) begin
            core_busy = (k < busy_cycles);
            #1;
            if (csr_access_o) begin
                acc_seen   = 1'b1;
                op_seen    = csr_op_o;
                addr_seen  = csr_addr_o;
                wdata_seen = csr_wdata_o;
            end else if (csr_op_o != 2'd0 || csr_addr_o != 12'd0 || csr_wdata_o != 32'd0) begin
                leak = 1'b1;
            end
            @(negedge clk);
            lat++;
            k++;
        end
        core_busy = 1'b0;
        chk({tag, "/latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, "/rdata"}, rsp_rdata_o, exp_rdata);
        chk({tag, "/err"}, {31'd0, rsp_err_o}, {31'd0, exp_err});
        chk({tag, "/access"}, {31'd0, acc_seen}, {31'd0, exp_acc});
        chk({tag, "/op"}, {30'd0, op_seen}, {30'd0, exp_op});
        chk({tag, "/addr"}, {20'd0, addr_seen}, {20'd0, exp_addr});
        chk({tag, "/wdata"}, wdata_seen, exp_wdata);
        chk({tag, "/idle_outputs"}, {31'd0, leak}, 32'd0);
        for (int i = 0; i < hold; i++) begin
            rsp_ready = 1'b0;
            #1;
            chk({tag, "/hold_valid"}, {31'd0, rsp_valid_o}, 32'd1);
            chk({tag, "/hold_rdata"}, rsp_rdata_o, exp_rdata);
            chk({tag, "/hold_err"}, {31'd0, rsp_err_o}, {31'd0, exp_err});
            chk({tag, "/hold_req_ready"}, {31'd0, req_ready_o}, 32'd0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        #1;
        chk({tag, "/valid_drop"}, {31'd0, rsp_valid_o}, 32'd0);
        chk({tag, "/req_ready_next"}, {31'd0, req_ready_o}, 32'd1);
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_op    = '0;
        rsp_ready = 1'b0;
        core_busy = 1'b0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst/req_ready", {31'd0, req_ready_o}, 32'd0);
        chk("rst/rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
        chk("rst/busy", {31'd0, busy_o}, 32'd0);
        chk("rst/err_cnt", {24'd0, err_cnt_o}, 32'd0);
        chk("rst/access", {31'd0, csr_access_o}, 32'd0);
        chk("rst/rdata", rsp_rdata_o, 32'd0);
        rst = 1'b0;
        #1;
        chk("rst/req_ready_after", {31'd0, req_ready_o}, 32'd1);
        @(negedge clk);

        // Write then read mepc
        send(12'h341, 2'd1, 32'h1000_0040);
        run_rsp("wr_mepc", 0, 0, 3, 32'h8000_0100, 1'b0, 1'b1, 2'd1, 12'h341, 32'h1000_0040);
        send(12'h341, 2'd0, 32'd0);
        run_rsp("rd_mepc", 0, 0, 3, 32'h1000_0040, 1'b0, 1'b1, 2'd0, 12'h341, 32'd0);

        // Set / clear on mstatus
        send(12'h300, 2'd2, 32'h8);
        run_rsp("set_mstatus", 0, 0, 3, 32'h1800, 1'b0, 1'b1, 2'd2, 12'h300, 32'h8);
        send(12'h300, 2'd0, 32'd0);
        run_rsp("rd_mstatus_set", 0, 0, 3, 32'h1808, 1'b0, 1'b1, 2'd0, 12'h300, 32'd0);
        send(12'h300, 2'd3, 32'h8);
        run_rsp("clr_mstatus", 0, 0, 3, 32'h1808, 1'b0, 1'b1, 2'd3, 12'h300, 32'h8);
        send(12'h300, 2'd0, 32'd0);
        run_rsp("rd_mstatus_clr", 0, 0, 3, 32'h1800, 1'b0, 1'b1, 2'd0, 12'h300, 32'd0);

        // Read-only violation demoted to a read
        send(12'hF14, 2'd1, 32'hFFFF_FFFF);
        run_rsp("ro_write", 0, 0, 3, 32'h21, 1'b1, 1'b1, 2'd0, 12'hF14, 32'hFFFF_FFFF);
        chk("ro_write/err_cnt", {24'd0, err_cnt_o}, 32'd1);
        send(12'hF14, 2'd0, 32'd0);
        run_rsp("ro_read", 0, 0, 3, 32'h21, 1'b0, 1'b1, 2'd0, 12'hF14, 32'd0);
        chk("ro_read/err_cnt", {24'd0, err_cnt_o}, 32'd1);

        // Busy for three WAIT cycles, released in the last WAIT cycle before timeout
        send(12'h341, 2'd0, 32'd0);
        run_rsp("busy3", 3, 0, 6, 32'h1000_0040, 1'b0, 1'b1, 2'd0, 12'h341, 32'd0);

        // Busy held: timeout after four WAIT cycles, no CSR access
        send(12'h341, 2'd1, 32'h5555_5555);
        run_rsp("timeout", 100, 0, 5, 32'd0, 1'b1, 1'b0, 2'd0, 12'd0, 32'd0);
        chk("timeout/err_cnt", {24'd0, err_cnt_o}, 32'd2);
        send(12'h341, 2'd0, 32'd0);
        run_rsp("rd_after_timeout", 0, 0, 3, 32'h1000_0040, 1'b0, 1'b1, 2'd0, 12'h341, 32'd0);

        // Response backpressure
        send(12'h300, 2'd0, 32'd0);
        run_rsp("backpressure", 0, 5, 3, 32'h1800, 1'b0, 1'b1, 2'd0, 12'h300, 32'd0);

        // Reset landing in ISSUE of a dscratch0 write
        send(12'h7B2, 2'd1, 32'h1234_5678);
        @(negedge clk);
        chk("rst_issue/access_pre", {31'd0, csr_access_o}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_issue/access", {31'd0, csr_access_o}, 32'd0);
        chk("rst_issue/op", {30'd0, csr_op_o}, 32'd0);
        chk("rst_issue/req_ready", {31'd0, req_ready_o}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_issue/rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
        chk("rst_issue/busy", {31'd0, busy_o}, 32'd0);
        chk("rst_issue/err_cnt", {24'd0, err_cnt_o}, 32'd0);
        chk("rst_issue/req_ready_after", {31'd0, req_ready_o}, 32'd1);
        @(negedge clk);
        send(12'h7B2, 2'd0, 32'd0);
        run_rsp("rd_dscratch0", 0, 0, 3, 32'hDEAD_BEEF, 1'b0, 1'b1, 2'd0, 12'h7B2, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
